// File: rtl/mmio_responder.sv
// IO-side register block for the single-cycle core: LEDs, seven-segment value,
// debounced switches/button with press latch, and a free-running cycle counter.
module mmio_responder #(
  parameter int unsigned LED_W           = 16,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              btn_in,
  output logic [LED_W-1:0]  led_out,
  output logic [31:0]       seg_value
);

  localparam logic [5:0] OFF_LED = 6'h00;
  localparam logic [5:0] OFF_SW  = 6'h01;
  localparam logic [5:0] OFF_BTN = 6'h02;
  localparam logic [5:0] OFF_SEG = 6'h03;
  localparam logic [5:0] OFF_CYC = 6'h04;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       off;
  logic             unused_addr;
  logic [SW_W-1:0]  sw_s1, sw_s2, sw_stable;
  logic [CNT_W-1:0] sw_cnt;
  logic             btn_s1, btn_s2, btn_stable;
  logic [CNT_W-1:0] btn_cnt;
  logic             btn_rise;
  logic             press;
  logic [31:0]      cyc_cnt;

  // Only word offsets inside the 256-byte window matter; the CPU did the range decode.
  assign off         = addr[7:2];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  // Same-cycle read mux so lw completes without a stall.
  always_comb begin
    rdata = '0;
    if (io_read) begin
      case (off)
        OFF_LED: rdata = 32'(led_out);
        OFF_SW:  rdata = 32'(sw_stable);
        OFF_BTN: rdata = {30'b0, btn_stable, press};
        OFF_SEG: rdata = seg_value;
        OFF_CYC: rdata = cyc_cnt;
        default: rdata = '0;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out   <= '0;
      seg_value <= '0;
    end else if (io_write) begin
      if (off == OFF_LED) led_out   <= wdata[LED_W-1:0];
      if (off == OFF_SEG) seg_value <= wdata;
    end
  end

  // Switch vector: 2-FF synchronizer then whole-vector debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      if (sw_s2 == sw_stable) begin
        sw_cnt <= '0;
      end else if (sw_cnt == DB_LAST) begin
        sw_stable <= sw_s2;
        sw_cnt    <= '0;
      end else begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
    end
  end

  // Button: same scheme as the switches, kept separate so each has its own timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_stable <= 1'b0;
      btn_cnt    <= '0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_stable) begin
        btn_cnt <= '0;
      end else if (btn_cnt == DB_LAST) begin
        btn_stable <= btn_s2;
        btn_cnt    <= '0;
      end else begin
        btn_cnt <= btn_cnt + CNT_W'(1);
      end
    end
  end

  assign btn_rise = btn_s2 && !btn_stable && (btn_cnt == DB_LAST);

  // Press latch: a new press beats a simultaneous clearing read so no press is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press <= 1'b0;
    end else if (btn_rise) begin
      press <= 1'b1;
    end else if (io_read && (off == OFF_BTN)) begin
      press <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (io_write && (off == OFF_CYC)) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: table-driven register vectors plus hand-written
// debounce, press-latch and cycle-counter sequences, checked through a scoreboard.
module tb_mmio_responder;

  localparam int unsigned DB      = 8;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_read, io_write;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] sw_in;
  logic        btn_in;
  logic [15:0] led_out;
  logic [31:0] seg_value;

  always #5 clk = ~clk;

  mmio_responder #(
    .LED_W(16), .SW_W(16), .DEBOUNCE_CYCLES(DB), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_read(io_read), .io_write(io_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .sw_in(sw_in), .btn_in(btn_in),
    .led_out(led_out), .seg_value(seg_value)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic [31:0] exp_seg;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at a falling edge, sample rdata 2ns later, end on the next falling edge.
  task automatic op(input bit rd, input bit wr, input logic [7:0] off, input logic [31:0] wd,
                    input bit chk, input logic [31:0] exp, input string name);
    sb_t e;
    io_read  = rd;
    io_write = wr;
    addr     = IO_BASE | {24'h0, off};
    wdata    = wd;
    if (chk) begin
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
    #2;
    if (chk) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        e = sb_q.pop_front();
        check(e.name, rdata, e.exp);
      end
    end
    @(negedge clk);
    io_read  = 1'b0;
    io_write = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] off, input logic [31:0] exp, input string name);
    op(1'b1, 1'b0, off, 32'h0, 1'b1, exp, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; io_read = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
    sw_in = 16'hFFFF; btn_in = 1'b0;

    // rd, wr, off, wdata, rdata, led after edge, seg after edge
    vt.push_back('{1'b1, 1'b1, 8'h00, 32'h1234_5678, 32'h0000_0000, 16'h5678, 32'h0000_0000});
    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_5678, 16'h5678, 32'h0000_0000});
    vt.push_back('{1'b1, 1'b1, 8'h0C, 32'hDEAD_BEEF, 32'h0000_0000, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b0, 8'h0C, 32'h0,         32'hDEAD_BEEF, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0000_0000, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b1, 8'hFC, 32'hFFFF_FFFF, 32'h0000_0000, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b0, 1'b0, 8'h00, 32'h0,         32'h0000_0000, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_5678, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b0, 8'h0C, 32'h0,         32'hDEAD_BEEF, 16'h5678, 32'hDEAD_BEEF});
    vt.push_back('{1'b0, 1'b1, 8'h00, 32'hFFFF_0001, 32'h0000_0000, 16'h0001, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_0001, 16'h0001, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, 1'b1, 8'h0C, 32'h0,         32'hDEAD_BEEF, 16'h0001, 32'h0000_0000});
    vt.push_back('{1'b1, 1'b0, 8'h04, 32'h0,         32'h0000_FFFF, 16'h0001, 32'h0000_0000});
    vt.push_back('{1'b1, 1'b1, 8'h04, 32'h0,         32'h0000_FFFF, 16'h0001, 32'h0000_0000});
    vt.push_back('{1'b1, 1'b0, 8'h04, 32'h0,         32'h0000_FFFF, 16'h0001, 32'h0000_0000});
    vt.push_back('{1'b1, 1'b0, 8'h08, 32'h0,         32'h0000_0000, 16'h0001, 32'h0000_0000});

    @(negedge clk);

    // Reset held with switches high.
    op(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0, "rst_idle_rdata");
    rd_chk(8'h10, 32'h0, "rst_cycle");
    rd_chk(8'h04, 32'h0, "rst_sw");
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_seg", seg_value, 32'h0);

    // Release; k counts rising edges since release.
    rst_n = 1'b1;
    rd_chk(8'h10, 32'h0, "cyc_k0");
    rd_chk(8'h10, 32'h1, "cyc_k1");
    idle(1);
    rd_chk(8'h04, 32'h0, "sw_after_rst_k3");
    idle(5);
    rd_chk(8'h04, 32'h0, "sw_after_rst_k9");
    rd_chk(8'h04, 32'h0000_FFFF, "sw_after_rst_k10");

    foreach (vt[i]) begin
      op(vt[i].rd, vt[i].wr, vt[i].off, vt[i].wd, 1'b1, vt[i].exp_rd, $sformatf("vec%0d_rdata", i));
      check($sformatf("vec%0d_led", i), 32'(led_out), 32'(vt[i].exp_led));
      check($sformatf("vec%0d_seg", i), seg_value, vt[i].exp_seg);
    end

    // Bounce rejection on sw_in[0].
    sw_in = 16'h0000;
    idle(12);
    rd_chk(8'h04, 32'h0, "sw_cleared");
    for (int p = 0; p < 3; p++) begin
      sw_in = 16'h0001;
      for (int k = 0; k < 5; k++) rd_chk(8'h04, 32'h0, $sformatf("bounce%0d_hi%0d", p, k));
      sw_in = 16'h0000;
      for (int k = 0; k < 5; k++) rd_chk(8'h04, 32'h0, $sformatf("bounce%0d_lo%0d", p, k));
    end
    sw_in = 16'h0001;
    for (int k = 0; k < 12; k++)
      rd_chk(8'h04, (k >= 10) ? 32'h1 : 32'h0, $sformatf("sw_hold_k%0d", k));

    // Button press, clearing reads, release.
    btn_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 12)      rd_chk(8'h08, 32'h3, "btn_press_first");
      else if (k == 13) rd_chk(8'h08, 32'h2, "btn_press_second");
      else              idle(1);
    end
    btn_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 9)       rd_chk(8'h08, 32'h2, "btn_release_k9");
      else if (k == 11) rd_chk(8'h08, 32'h0, "btn_release_k11");
      else              idle(1);
    end

    // Debounced rising edge on the same edge as a clearing read.
    btn_in = 1'b1;
    idle(9);
    rd_chk(8'h08, 32'h0, "btn_race_pre");
    rd_chk(8'h08, 32'h3, "btn_race_set_wins");
    rd_chk(8'h08, 32'h2, "btn_race_cleared");
    btn_in = 1'b0;
    idle(12);

    // Cycle counter clear, elapsed count, read-with-write.
    op(1'b0, 1'b1, 8'h10, 32'h1234_5678, 1'b1, 32'h0, "cyc_wr_rdata");
    rd_chk(8'h10, 32'd0, "cyc_after_clear");
    idle(3);
    rd_chk(8'h10, 32'd4, "cyc_elapsed");
    op(1'b1, 1'b1, 8'h10, 32'h0, 1'b1, 32'd5, "cyc_rw_old");
    rd_chk(8'h10, 32'd0, "cyc_rw_cleared");
    rd_chk(8'h10, 32'd1, "cyc_rw_next");

    // Wrap from all-ones.
    force dut.cyc_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_cnt;
    rd_chk(8'h10, 32'hFFFF_FFFE, "cyc_deposit");
    rd_chk(8'h10, 32'hFFFF_FFFF, "cyc_max");
    rd_chk(8'h10, 32'h0000_0000, "cyc_wrap");
    rd_chk(8'h10, 32'h0000_0001, "cyc_after_wrap");

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
